// File: rtl/midi_voice_alloc.sv
// Polyphonic voice scheduler: maps MIDI note events onto VOICES shared synth voices.
// Retriggers a note that is already sounding, otherwise takes the lowest free voice, or steals
// the oldest voice when every voice is busy. CC 123 releases every active voice.
module midi_voice_alloc #(
    parameter int unsigned VOICES = 6,
    parameter int unsigned VIDX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              note_on,
    input  logic              note_off,
    input  logic              cc_send,
    input  logic [3:0]        mchannel,
    input  logic [6:0]        note,
    input  logic [6:0]        velocity,
    input  logic [6:0]        cc,
    output logic              voice_on,
    output logic              voice_off,
    output logic [VIDX_W-1:0] voice_idx,
    output logic [3:0]        voice_ch,
    output logic [6:0]        voice_note,
    output logic [6:0]        voice_vel,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StDecide,
        StIssueOff,
        StIssueOn,
        StAllOff
    } state_e;

    typedef enum logic [1:0] {
        EvOn,
        EvOff,
        EvAll
    } ev_e;

    // FSM and scan index
    state_e            state_q, state_d;
    logic [VIDX_W-1:0] scan_q, scan_d;
    logic [VIDX_W-1:0] tgt_q, tgt_d;

    // Work registers: the event currently being serviced
    ev_e        w_type_q, w_type_d;
    logic [3:0] w_ch_q, w_ch_d;
    logic [6:0] w_note_q, w_note_d;
    logic [6:0] w_vel_q, w_vel_d;

    // One-deep pending event
    logic       p_valid_q, p_valid_d;
    ev_e        p_type_q, p_type_d;
    logic [3:0] p_ch_q, p_ch_d;
    logic [6:0] p_note_q, p_note_d;
    logic [6:0] p_vel_q, p_vel_d;

    // Scan results
    logic              m_found_q, m_found_d;
    logic [VIDX_W-1:0] m_idx_q, m_idx_d;
    logic              f_found_q, f_found_d;
    logic [VIDX_W-1:0] f_idx_q, f_idx_d;
    logic              o_found_q, o_found_d;
    logic [VIDX_W-1:0] o_idx_q, o_idx_d;
    logic [7:0]        o_age_q, o_age_d;

    // Voice table
    logic [VOICES-1:0]      act_q, act_d;
    logic [VOICES-1:0][3:0] tch_q, tch_d;
    logic [VOICES-1:0][6:0] tnote_q, tnote_d;
    logic [VOICES-1:0][7:0] tage_q, tage_d;

    // Registered outputs
    logic              von_q, von_d;
    logic              voff_q, voff_d;
    logic [VIDX_W-1:0] oidx_q, oidx_d;
    logic [3:0]        och_q, och_d;
    logic [6:0]        onote_q, onote_d;
    logic [6:0]        ovel_q, ovel_d;
    logic              ovf_q, ovf_d;

    // Incoming event decode; note_off beats note_on beats CC 123
    logic in_ev;
    ev_e  in_type;
    assign in_ev   = note_off | note_on | (cc_send & (cc == 7'd123));
    assign in_type = note_off ? EvOff : (note_on ? EvOn : EvAll);

    // Table lookups for the scanned voice and for the oldest voice
    logic       cur_act;
    logic [3:0] cur_ch;
    logic [6:0] cur_note;
    logic [7:0] cur_age;
    logic [3:0] old_ch;
    logic [6:0] old_note;
    logic       last_idx;

    // Mux the table entries addressed by the scan index and the oldest-voice index
    always_comb begin
        cur_act  = 1'b0;
        cur_ch   = '0;
        cur_note = '0;
        cur_age  = '0;
        old_ch   = '0;
        old_note = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (scan_q == VIDX_W'(i)) begin
                cur_act  = act_q[i];
                cur_ch   = tch_q[i];
                cur_note = tnote_q[i];
                cur_age  = tage_q[i];
            end
            if (o_idx_q == VIDX_W'(i)) begin
                old_ch   = tch_q[i];
                old_note = tnote_q[i];
            end
        end
    end

    assign last_idx = (scan_q == VIDX_W'(VOICES - 1));

    // Next-state logic: event intake, scan, decision, issue and all-notes-off walk
    always_comb begin
        logic start;
        ev_e  start_type;

        state_d   = state_q;
        scan_d    = scan_q;
        tgt_d     = tgt_q;
        w_type_d  = w_type_q;
        w_ch_d    = w_ch_q;
        w_note_d  = w_note_q;
        w_vel_d   = w_vel_q;
        p_valid_d = p_valid_q;
        p_type_d  = p_type_q;
        p_ch_d    = p_ch_q;
        p_note_d  = p_note_q;
        p_vel_d   = p_vel_q;
        m_found_d = m_found_q;
        m_idx_d   = m_idx_q;
        f_found_d = f_found_q;
        f_idx_d   = f_idx_q;
        o_found_d = o_found_q;
        o_idx_d   = o_idx_q;
        o_age_d   = o_age_q;
        act_d     = act_q;
        tch_d     = tch_q;
        tnote_d   = tnote_q;
        tage_d    = tage_q;
        von_d     = 1'b0;
        voff_d    = 1'b0;
        oidx_d    = oidx_q;
        och_d     = och_q;
        onote_d   = onote_q;
        ovel_d    = ovel_q;
        ovf_d     = 1'b0;
        start      = 1'b0;
        start_type = EvOn;

        // While busy, new events park in pending or are dropped
        if (state_q != StIdle && in_ev) begin
            if (!p_valid_q) begin
                p_valid_d = 1'b1;
                p_type_d  = in_type;
                p_ch_d    = mchannel;
                p_note_d  = note;
                p_vel_d   = velocity;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (p_valid_q) begin
                    start      = 1'b1;
                    start_type = p_type_q;
                    w_ch_d     = p_ch_q;
                    w_note_d   = p_note_q;
                    w_vel_d    = p_vel_q;
                    // Pending slot frees up this cycle, so a new event can refill it
                    p_valid_d  = in_ev;
                    if (in_ev) begin
                        p_type_d = in_type;
                        p_ch_d   = mchannel;
                        p_note_d = note;
                        p_vel_d  = velocity;
                    end
                end else if (in_ev) begin
                    start      = 1'b1;
                    start_type = in_type;
                    w_ch_d     = mchannel;
                    w_note_d   = note;
                    w_vel_d    = velocity;
                end
            end

            StScan: begin
                if (!m_found_q && cur_act && cur_ch == w_ch_q && cur_note == w_note_q) begin
                    m_found_d = 1'b1;
                    m_idx_d   = scan_q;
                end
                if (!f_found_q && !cur_act) begin
                    f_found_d = 1'b1;
                    f_idx_d   = scan_q;
                end
                // Strict compare keeps the lowest index on equal ages
                if (cur_act && (!o_found_q || cur_age > o_age_q)) begin
                    o_found_d = 1'b1;
                    o_idx_d   = scan_q;
                    o_age_d   = cur_age;
                end
                if (last_idx) begin
                    state_d = StDecide;
                end else begin
                    scan_d = scan_q + VIDX_W'(1);
                end
            end

            StDecide: begin
                if (w_type_q == EvOn) begin
                    if (m_found_q || f_found_q) begin
                        tgt_d   = m_found_q ? m_idx_q : f_idx_q;
                        von_d   = 1'b1;
                        oidx_d  = m_found_q ? m_idx_q : f_idx_q;
                        och_d   = w_ch_q;
                        onote_d = w_note_q;
                        ovel_d  = w_vel_q;
                        state_d = StIssueOn;
                    end else begin
                        // Steal: release the oldest voice before restarting it
                        tgt_d   = o_idx_q;
                        voff_d  = 1'b1;
                        oidx_d  = o_idx_q;
                        och_d   = old_ch;
                        onote_d = old_note;
                        state_d = StIssueOff;
                    end
                end else if (m_found_q) begin
                    tgt_d   = m_idx_q;
                    voff_d  = 1'b1;
                    oidx_d  = m_idx_q;
                    och_d   = w_ch_q;
                    onote_d = w_note_q;
                    state_d = StIssueOff;
                end else begin
                    state_d = StIdle;
                end
            end

            StIssueOff: begin
                for (int i = 0; i < VOICES; i++) begin
                    if (tgt_q == VIDX_W'(i)) act_d[i] = 1'b0;
                end
                if (w_type_q == EvOn) begin
                    von_d   = 1'b1;
                    oidx_d  = tgt_q;
                    och_d   = w_ch_q;
                    onote_d = w_note_q;
                    ovel_d  = w_vel_q;
                    state_d = StIssueOn;
                end else begin
                    state_d = StIdle;
                end
            end

            StIssueOn: begin
                for (int i = 0; i < VOICES; i++) begin
                    if (tgt_q == VIDX_W'(i)) begin
                        act_d[i]   = 1'b1;
                        tch_d[i]   = w_ch_q;
                        tnote_d[i] = w_note_q;
                        tage_d[i]  = 8'd0;
                    end else if (act_q[i] && tage_q[i] != 8'hFF) begin
                        tage_d[i] = tage_q[i] + 8'd1;
                    end
                end
                state_d = StIdle;
            end

            StAllOff: begin
                if (cur_act) begin
                    voff_d  = 1'b1;
                    oidx_d  = scan_q;
                    och_d   = cur_ch;
                    onote_d = cur_note;
                end
                for (int i = 0; i < VOICES; i++) begin
                    if (scan_q == VIDX_W'(i)) act_d[i] = 1'b0;
                end
                if (last_idx) begin
                    state_d = StIdle;
                end else begin
                    scan_d = scan_q + VIDX_W'(1);
                end
            end

            default: state_d = StIdle;
        endcase

        if (start) begin
            w_type_d  = start_type;
            scan_d    = '0;
            m_found_d = 1'b0;
            f_found_d = 1'b0;
            o_found_d = 1'b0;
            o_age_d   = '0;
            state_d   = (start_type == EvAll) ? StAllOff : StScan;
        end
    end

    // State, table and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            scan_q    <= '0;
            tgt_q     <= '0;
            w_type_q  <= EvOn;
            w_ch_q    <= '0;
            w_note_q  <= '0;
            w_vel_q   <= '0;
            p_valid_q <= 1'b0;
            p_type_q  <= EvOn;
            p_ch_q    <= '0;
            p_note_q  <= '0;
            p_vel_q   <= '0;
            m_found_q <= 1'b0;
            m_idx_q   <= '0;
            f_found_q <= 1'b0;
            f_idx_q   <= '0;
            o_found_q <= 1'b0;
            o_idx_q   <= '0;
            o_age_q   <= '0;
            act_q     <= '0;
            tch_q     <= '0;
            tnote_q   <= '0;
            tage_q    <= '0;
            von_q     <= 1'b0;
            voff_q    <= 1'b0;
            oidx_q    <= '0;
            och_q     <= '0;
            onote_q   <= '0;
            ovel_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            scan_q    <= scan_d;
            tgt_q     <= tgt_d;
            w_type_q  <= w_type_d;
            w_ch_q    <= w_ch_d;
            w_note_q  <= w_note_d;
            w_vel_q   <= w_vel_d;
            p_valid_q <= p_valid_d;
            p_type_q  <= p_type_d;
            p_ch_q    <= p_ch_d;
            p_note_q  <= p_note_d;
            p_vel_q   <= p_vel_d;
            m_found_q <= m_found_d;
            m_idx_q   <= m_idx_d;
            f_found_q <= f_found_d;
            f_idx_q   <= f_idx_d;
            o_found_q <= o_found_d;
            o_idx_q   <= o_idx_d;
            o_age_q   <= o_age_d;
            act_q     <= act_d;
            tch_q     <= tch_d;
            tnote_q   <= tnote_d;
            tage_q    <= tage_d;
            von_q     <= von_d;
            voff_q    <= voff_d;
            oidx_q    <= oidx_d;
            och_q     <= och_d;
            onote_q   <= onote_d;
            ovel_q    <= ovel_d;
            ovf_q     <= ovf_d;
        end
    end

    assign voice_on   = von_q;
    assign voice_off  = voff_q;
    assign voice_idx  = oidx_q;
    assign voice_ch   = och_q;
    assign voice_note = onote_q;
    assign voice_vel  = ovel_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != StIdle);

endmodule
